// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared types, limits and BCD helpers for the MM:SS clock.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_MIN = 2'd1,
    MODE_SET_SEC = 2'd2
  } mode_t;

  localparam logic [3:0] ONES_MAX  = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  localparam logic [3:0] BLANK_MIN = 4'b1100;
  localparam logic [3:0] BLANK_SEC = 4'b0011;

  // One two-digit BCD field counting 00..59 (minutes or seconds).
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd60_t;

  // True when the field sits at 59, i.e. the next step wraps to 00.
  function automatic logic bcd60_at_max(bcd60_t v);
    return (v.tens == TENS_MAX) && (v.ones == ONES_MAX);
  endfunction

  // Modulo-60 BCD increment; >= comparisons pull any stray code back in range.
  function automatic bcd60_t bcd60_inc(bcd60_t v);
    bcd60_t r;
    r = v;
    if (v.ones >= ONES_MAX) begin
      r.ones = 4'd0;
      if (v.tens >= TENS_MAX) r.tens = 4'd0;
      else                    r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_set_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : clock_set_ctrl_if
//  Description : Strobe/button inputs and display outputs of clock_set_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clock_set_ctrl_if;

  logic       tick_1hz;
  logic       tick_2hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] blank;
  logic [1:0] mode;
  logic       hour_pulse;

  // Environment side: prescaler strobes and buttons in, display data out.
  modport master (
    output tick_1hz, tick_2hz, btn_mode, btn_inc,
    input  min_tens, min_ones, sec_tens, sec_ones, blank, mode, hour_pulse
  );

  // Controller side.
  modport slave (
    input  tick_1hz, tick_2hz, btn_mode, btn_inc,
    output min_tens, min_ones, sec_tens, sec_ones, blank, mode, hour_pulse
  );

endinterface
`default_nettype wire

// File: rtl/clock_set_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-FF synchronizer, level debouncer and press (0->1) event.
//                Raw edge to press_ev latency is DEBOUNCE_CYC + 3 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int CNT_W        = 19
) (
  input  logic clk,
  input  logic res,
  input  logic btn_raw,
  output logic press_ev
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync_1;
  logic             sync_2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button level into the clk domain.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  // Count consecutive samples that differ from the accepted level; any
  // return to the accepted level restarts the count.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_2 == stable) begin
      cnt    <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      stable <= sync_2;
    end else begin
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // One-cycle event on an accepted press; releases produce nothing.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      stable_d <= 1'b0;
      press_ev <= 1'b0;
    end else begin
      stable_d <= stable;
      press_ev <= stable & ~stable_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_set_ctrl
//  Description : MM:SS timekeeping with RUN / SET_MIN / SET_SEC modes,
//                two-button editing and per-digit blink masks.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int CNT_W        = 19
) (
  input  logic             clk,
  input  logic             res,
  clock_set_ctrl_if.slave  bus
);

  logic       mode_ev;
  logic       inc_ev;

  mode_t      state;
  mode_t      state_nxt;
  bcd60_t     min_q;
  bcd60_t     min_nxt;
  bcd60_t     sec_q;
  bcd60_t     sec_nxt;
  logic       blink_phase;
  logic       phase_nxt;
  logic [3:0] blank_q;
  logic [3:0] blank_nxt;
  logic       hour_q;
  logic       hour_nxt;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (CNT_W)
  ) u_deb_mode (
    .clk      (clk),
    .res      (res),
    .btn_raw  (bus.btn_mode),
    .press_ev (mode_ev)
  );

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (CNT_W)
  ) u_deb_inc (
    .clk      (clk),
    .res      (res),
    .btn_raw  (bus.btn_inc),
    .press_ev (inc_ev)
  );

  // Next mode, counters, blink phase and mask; mode_ev beats inc_ev.
  always_comb begin
    state_nxt = state;
    min_nxt   = min_q;
    sec_nxt   = sec_q;
    phase_nxt = blink_phase;
    hour_nxt  = 1'b0;
    blank_nxt = 4'b0000;

    case (state)
      MODE_RUN: begin
        // A tick coinciding with mode_ev is still applied.
        if (bus.tick_1hz) begin
          sec_nxt = bcd60_inc(sec_q);
          if (bcd60_at_max(sec_q)) begin
            min_nxt  = bcd60_inc(min_q);
            hour_nxt = bcd60_at_max(min_q);
          end
        end
        if (mode_ev) state_nxt = MODE_SET_MIN;
      end
      MODE_SET_MIN: begin
        if (mode_ev)     state_nxt = MODE_SET_SEC;
        else if (inc_ev) min_nxt   = bcd60_inc(min_q);
      end
      MODE_SET_SEC: begin
        if (mode_ev)     state_nxt = MODE_RUN;
        else if (inc_ev) sec_nxt   = bcd60_inc(sec_q);
      end
      default: state_nxt = MODE_RUN;
    endcase

    // Restart blinking in the visible phase whenever the mode changes.
    if (mode_ev)
      phase_nxt = 1'b0;
    else if (bus.tick_2hz && (state != MODE_RUN))
      phase_nxt = ~blink_phase;

    if (phase_nxt) begin
      if (state_nxt == MODE_SET_MIN)      blank_nxt = BLANK_MIN;
      else if (state_nxt == MODE_SET_SEC) blank_nxt = BLANK_SEC;
    end
  end

  // Register the mode FSM together with every visible output.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state       <= MODE_RUN;
      min_q       <= '0;
      sec_q       <= '0;
      blink_phase <= 1'b0;
      blank_q     <= 4'b0000;
      hour_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      min_q       <= min_nxt;
      sec_q       <= sec_nxt;
      blink_phase <= phase_nxt;
      blank_q     <= blank_nxt;
      hour_q      <= hour_nxt;
    end
  end

  assign bus.min_tens   = min_q.tens;
  assign bus.min_ones   = min_q.ones;
  assign bus.sec_tens   = sec_q.tens;
  assign bus.sec_ones   = sec_q.ones;
  assign bus.blank      = blank_q;
  assign bus.mode       = state;
  assign bus.hour_pulse = hour_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_set_ctrl
//  Description : Directed self-checking bench for clock_set_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clock_set_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = DEB + 8;

  logic clk = 1'b0;
  logic res = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int hp_cnt   = 0;
  int hp_base;
  logic found;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .CNT_W        (3)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] time_bcd;
  assign time_bcd = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};

  // Count every cycle in which hour_pulse is high.
  always @(negedge clk) if (bus.hour_pulse === 1'b1) hp_cnt++;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
  endtask

  task automatic tick2();
    bus.tick_2hz = 1'b1;
    step();
    bus.tick_2hz = 1'b0;
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1;
    repeat (HOLD) step();
    bus.btn_mode = 1'b0;
    repeat (HOLD) step();
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      bus.btn_inc = 1'b1;
      repeat (HOLD) step();
      bus.btn_inc = 1'b0;
      repeat (HOLD) step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick_1hz = 1'b0;
    bus.tick_2hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    repeat (3) step();
    check_value("rst_time",  time_bcd,       16'h0000);
    check_value("rst_mode",  bus.mode,       2'd0);
    check_value("rst_blank", bus.blank,      4'b0000);
    check_value("rst_hour",  bus.hour_pulse, 1'b0);
    res = 1'b0;
    step();

    // 1: 65 seconds of running
    for (int i = 0; i < 65; i++) begin
      tick1();
      step();
    end
    check_value("t1_time",  time_bcd,  16'h0105);
    check_value("t1_blank", bus.blank, 4'b0000);
    check_value("t1_mode",  bus.mode,  2'd0);

    // 2: preload 59:58 then roll over the hour
    press_mode();
    check_value("t2_set_min", bus.mode, 2'd1);
    press_inc(58);
    check_value("t2_min59", time_bcd, 16'h5905);
    press_mode();
    check_value("t2_set_sec", bus.mode, 2'd2);
    press_inc(53);
    check_value("t2_5958", time_bcd, 16'h5958);
    press_mode();
    check_value("t2_run", bus.mode, 2'd0);
    tick1();
    check_value("t2_5959", time_bcd, 16'h5959);
    check_value("t2_no_hp", bus.hour_pulse, 1'b0);
    tick1();
    check_value("t2_wrap", time_bcd, 16'h0000);
    check_value("t2_hp_hi", bus.hour_pulse, 1'b1);
    step();
    check_value("t2_hp_lo", bus.hour_pulse, 1'b0);
    check_value("t2_hp_cnt", hp_cnt, 1);

    // 3: bouncing mode button, then clean hold
    for (int i = 0; i < 2; i++) begin
      bus.btn_mode = 1'b1; step(); step();
      bus.btn_mode = 1'b0; step(); step();
    end
    bus.btn_mode = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check_value($sformatf("t3_mode_c%0d", k), bus.mode, (k >= 8) ? 2'd1 : 2'd0);
    end
    bus.btn_mode = 1'b0;
    repeat (20) step();
    check_value("t3_release", bus.mode, 2'd1);

    // 4: reach SET_MIN at 58:30, then wrap minutes with ticks ignored
    press_inc(58);
    press_mode();
    press_inc(30);
    press_mode();
    press_mode();
    check_value("t4_mode", bus.mode, 2'd1);
    check_value("t4_5830", time_bcd, 16'h5830);
    hp_base = hp_cnt;
    press_inc(2);
    check_value("t4_0030", time_bcd, 16'h0030);
    press_inc(1);
    repeat (5) begin
      tick1();
      step();
    end
    check_value("t4_0130", time_bcd, 16'h0130);
    check_value("t4_no_hp", hp_cnt, hp_base);

    // 5: blink in SET_SEC, then back to RUN
    press_mode();
    check_value("t5_mode", bus.mode, 2'd2);
    check_value("t5_blank0", bus.blank, 4'b0000);
    tick2();
    check_value("t5_blank1", bus.blank, 4'b0011);
    repeat (3) step();
    tick2();
    check_value("t5_blank2", bus.blank, 4'b0000);
    tick2();
    check_value("t5_blank3", bus.blank, 4'b0011);
    bus.btn_mode = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (bus.mode == 2'd0) found = 1'b1;
    end
    check_value("t5_run_reached", found, 1'b1);
    check_value("t5_blank_run", bus.blank, 4'b0000);
    bus.btn_mode = 1'b0;
    repeat (HOLD) step();

    // 6: simultaneous mode+inc in SET_MIN, then reset mid-edit
    press_mode();
    check_value("t6_set_min", bus.mode, 2'd1);
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    repeat (HOLD) step();
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    repeat (HOLD) step();
    check_value("t6_mode", bus.mode, 2'd2);
    check_value("t6_time", time_bcd, 16'h0130);
    tick2();
    check_value("t6_blank_pre", bus.blank, 4'b0011);
    res = 1'b1;
    #2;
    check_value("t6_rst_time",  time_bcd,  16'h0000);
    check_value("t6_rst_mode",  bus.mode,  2'd0);
    check_value("t6_rst_blank", bus.blank, 4'b0000);
    step();
    res = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Timekeeping and time-setting controller for the 4-digit MM:SS multiplexed display.
- Owns the BCD minute/second counters and sequences them through RUN / SET_MIN / SET_SEC modes, driven by two push-buttons.
- Produces per-digit blank masks for blinking the field being edited.
- Feeds the existing segment decoder and scan logic. Consumes 1 Hz and 2 Hz strobes from the prescaler.

Parameters:
- DEBOUNCE_CYC, 500000, cycles a synchronized button level must hold stable before it is accepted (10 ms at 50 MHz).
- CNT_W, 19, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYC.

Ports:
- clk  in  1  system clock (50 MHz).
- res  in  1  reset; asynchronous, active-high.
- tick_1hz  in  1  one-cycle strobe, once per second.
- tick_2hz  in  1  one-cycle strobe, twice per second; blink timebase.
- btn_mode  in  1  raw mode button, active-high, asynchronous to clk.
- btn_inc  in  1  raw increment button, active-high, asynchronous to clk.
- min_tens  out  4  BCD minutes tens, 0..5.
- min_ones  out  4  BCD minutes ones, 0..9.
- sec_tens  out  4  BCD seconds tens, 0..5.
- sec_ones  out  4  BCD seconds ones, 0..9.
- blank  out  4  digit blank mask; bit3=min_tens, bit2=min_ones, bit1=sec_tens, bit0=sec_ones; 1 = digit off.
- mode  out  2  current state: 0=RUN, 1=SET_MIN, 2=SET_SEC.
- hour_pulse  out  1  one-cycle strobe on rollover 59:59 -> 00:00.

Behaviour:
- Reset (async, res=1): all BCD digits 0; mode=RUN; blank=0000; hour_pulse=0; blink_phase=0; debouncers cleared, with the stable level taken as 0.
- Button path:
  - Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debouncer counter resets on any change of the synchronized level. After DEBOUNCE_CYC consecutive equal samples, the stable level updates.
  - A stable-level 0->1 transition produces a one-cycle press event (mode_ev / inc_ev).
  - Latency from raw edge to press event: DEBOUNCE_CYC + 3 cycles. Release generates no event. No auto-repeat.
- FSM, advanced on mode_ev: RUN -> SET_MIN -> SET_SEC -> RUN.
- RUN:
  - On tick_1hz, seconds increment in BCD with carry: sec_ones 9 -> 0 carries into sec_tens; sec_tens 5 with ones 9 -> 00 carries into minutes; min 59 -> 00.
  - On the full 59:59 -> 00:00 rollover, hour_pulse=1 for that same update cycle.
  - inc_ev is ignored in RUN.
- SET_MIN:
  - tick_1hz is ignored (clock paused).
  - inc_ev increments minutes modulo 60 (59 -> 00); no carry out, seconds unchanged, no hour_pulse.
- SET_SEC:
  - tick_1hz is ignored.
  - inc_ev increments seconds modulo 60 with no carry into minutes.
- Leaving SET_SEC for RUN: counting resumes at the next tick_1hz. No catch-up for ticks missed while setting.
- Blink:
  - blink_phase toggles on each tick_2hz in SET states. It is forced to 0 on every mode change, so the edited field is visible immediately.
  - blank = 1100 in SET_MIN when blink_phase=1, 0011 in SET_SEC when blink_phase=1, otherwise 0000. RUN always gives 0000.
- Simultaneous events in one cycle:
  - mode_ev and inc_ev together: mode_ev wins and inc_ev is dropped.
  - RUN with tick_1hz and mode_ev together: the tick is applied and mode becomes SET_MIN in the same cycle.
- All outputs are registered; a counter update is visible the cycle after its strobe.
- A BCD digit is never observed outside its range.
- Reset mid-edit returns to RUN at 00:00.

Decomposition:
- Package clock_pkg:
  - mode encodings MODE_RUN/MODE_SET_MIN/MODE_SET_SEC (2-bit);
  - BCD limits ONES_MAX=9 and TENS_MAX=5;
  - blank masks BLANK_MIN=4'b1100, BLANK_SEC=4'b0011.
- Sub-module btn_debounce (synchronizer + debounce counter + rising-edge event), parameterized by DEBOUNCE_CYC and CNT_W and instantiated twice.
- The BCD 60-counter step is a function in clock_pkg shared by the minute and second fields.

Test Plan:
All scenarios use DEBOUNCE_CYC=4.
1. Reset, then 65 tick_1hz strobes in RUN -> digits read 01:05, blank=0000, mode=0.
2. Preload 59:58 via SET modes, return to RUN, apply 2 ticks -> 59:59, then 00:00 with hour_pulse high for exactly one cycle.
3. btn_mode bounce pattern 1,0,1,0 each 2 cycles, then held high for 10 cycles -> exactly one mode_ev, 7 cycles after the final rising edge; mode=1.
4. SET_MIN at 58:30, 3 inc presses, 5 ticks -> 01:30 (wrap 59 -> 00 -> 01), seconds frozen, no hour_pulse.
5. SET_SEC, tick_2hz strobes -> blank alternates 0011/0000 starting with 0011 after the first strobe; mode press to RUN -> blank=0000 the next cycle.
6. mode and inc events in the same cycle in SET_MIN -> mode=2, minutes unchanged. Assert res while in SET_SEC -> immediately 00:00, mode=0.
